// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - fetch/decode to issue handshake bundle
//
// Groups the decoded-instruction handshake presented by fetch to the
// issue controller.
//   if_valid            fetch presents a decoded instruction
//   if_ready            issue controller accepts it this cycle
//   dec_rd/rs1/rs2      decoded register fields
//   dec_rd_wen          instruction writes rd
//   dec_uses_rs2        instruction reads rs2
//   dec_stall           instruction is a branch
//   dec_mem_opcode      memory operation code
//   dec_mem_rdata_valid instruction is a load
// master: fetch side, slave: issue controller side.

interface issue_ctrl_if;
    logic       if_valid;
    logic       if_ready;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_rd_wen;
    logic       dec_uses_rs2;
    logic       dec_stall;
    logic [2:0] dec_mem_opcode;
    logic       dec_mem_rdata_valid;

    modport master (
        output if_valid,
        output dec_rd,
        output dec_rs1,
        output dec_rs2,
        output dec_rd_wen,
        output dec_uses_rs2,
        output dec_stall,
        output dec_mem_opcode,
        output dec_mem_rdata_valid,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  dec_rd,
        input  dec_rs1,
        input  dec_rs2,
        input  dec_rd_wen,
        input  dec_uses_rs2,
        input  dec_stall,
        input  dec_mem_opcode,
        input  dec_mem_rdata_valid,
        output if_ready
    );
endinterface

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order single-issue controller with branch/memory waits and load-use bubble
//
// Parameters
//   MEM_NOP      dec_mem_opcode value meaning "no memory access"
//   MEM_TIMEOUT  MEM_WAIT cycles allowed before flagging mem_err (1-255)
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   fetch      decoded-instruction handshake (slave side)
//   br_done    branch resolved (honoured only in BR_WAIT)
//   br_taken   branch taken, qualified by br_done
//   mem_ack    memory operation complete (honoured only in MEM_WAIT)
//   issue      one-cycle pulse per accepted instruction
//   mem_req    memory request, high throughout MEM_WAIT
//   flush      one-cycle pulse on a taken branch
//   bubble     load-use bubble inserted this cycle
//   mem_err    sticky memory timeout flag
//   stall_cnt  saturating count of cycles with if_valid=1 and if_ready=0
//   state      RUN=0, BR_WAIT=1, MEM_WAIT=2, LU_BUBBLE=3

module issue_ctrl #(
    parameter logic [2:0] MEM_NOP     = 3'b111,
    parameter int          MEM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    issue_ctrl_if.slave       fetch,
    input  logic              br_done,
    input  logic              br_taken,
    input  logic              mem_ack,
    output logic              issue,
    output logic              mem_req,
    output logic              flush,
    output logic              bubble,
    output logic              mem_err,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_BR_WAIT   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd2;
    localparam logic [1:0] ST_LU_BUBBLE = 2'd3;

    // The timeout counter starts at 0 on the first MEM_WAIT cycle, so the
    // MEM_TIMEOUT-th wait cycle is the one where it holds MEM_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [4:0] lu_rd;
    logic       lu_pend;
    logic [7:0] mem_cnt;

    logic in_run;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic accept;
    logic is_load;
    logic is_mem_op;
    logic timeout_hit;
    logic stall_now;

    // x0 is never a real producer, so a zero source field cannot collide.
    assign rs1_hit = lu_pend && (fetch.dec_rs1 != 5'd0) && (fetch.dec_rs1 == lu_rd);
    assign rs2_hit = lu_pend && fetch.dec_uses_rs2 && (fetch.dec_rs2 != 5'd0)
                     && (fetch.dec_rs2 == lu_rd);
    assign hazard  = rs1_hit || rs2_hit;

    assign in_run  = (state == ST_RUN);
    assign accept  = fetch.if_valid && in_run && !hazard;
    assign bubble  = fetch.if_valid && in_run && hazard;

    assign fetch.if_ready = accept;
    assign issue          = accept;

    assign mem_req = (state == ST_MEM_WAIT);
    assign flush   = (state == ST_BR_WAIT) && br_done && br_taken;

    assign is_load     = fetch.dec_mem_rdata_valid && fetch.dec_rd_wen && (fetch.dec_rd != 5'd0);
    assign is_mem_op   = (fetch.dec_mem_opcode != MEM_NOP);
    assign timeout_hit = (mem_cnt == TIMEOUT_LAST);
    assign stall_now   = fetch.if_valid && !accept && (stall_cnt != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            lu_rd     <= 5'd0;
            lu_pend   <= 1'b0;
            mem_cnt   <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            if (stall_now) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            case (state)
                ST_RUN: begin
                    if (accept) begin
                        // Only a load to a real register leaves a pending
                        // result; anything else retires the old one.
                        lu_pend <= is_load;
                        if (is_load) begin
                            lu_rd <= fetch.dec_rd;
                        end
                        // A branch that also carries a memory op waits for
                        // the branch only.
                        if (fetch.dec_stall) begin
                            state <= ST_BR_WAIT;
                        end else if (is_mem_op) begin
                            state   <= ST_MEM_WAIT;
                            mem_cnt <= 8'd0;
                        end
                    end else if (bubble) begin
                        lu_pend <= 1'b0;
                        state   <= ST_LU_BUBBLE;
                    end
                end

                ST_BR_WAIT: begin
                    if (br_done) begin
                        state <= ST_RUN;
                    end
                end

                ST_MEM_WAIT: begin
                    // An ack arriving on the timeout cycle still counts as
                    // success.
                    if (mem_ack) begin
                        state <= ST_RUN;
                    end else if (timeout_hit) begin
                        mem_err <= 1'b1;
                        lu_pend <= 1'b0;
                        state   <= ST_RUN;
                    end else begin
                        mem_cnt <= mem_cnt + 8'd1;
                    end
                end

                ST_LU_BUBBLE: begin
                    state <= ST_RUN;
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - self-checking bench for issue_ctrl

module tb_issue_ctrl;

    localparam logic [2:0] OP_NOP = 3'b111;
    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_ST  = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_done;
    logic        br_taken;
    logic        mem_ack;
    logic        issue;
    logic        mem_req;
    logic        flush;
    logic        bubble;
    logic        mem_err;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    int vectors = 0;
    int miscompares = 0;
    int exp_stall = 0;

    logic [14:0] exp_q[$];

    issue_ctrl_if fetch();

    issue_ctrl #(.MEM_NOP(3'b111), .MEM_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch     (fetch.slave),
        .br_done   (br_done),
        .br_taken  (br_taken),
        .mem_ack   (mem_ack),
        .issue     (issue),
        .mem_req   (mem_req),
        .flush     (flush),
        .bubble    (bubble),
        .mem_err   (mem_err),
        .stall_cnt (stall_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every issue pulse must match the oldest expected tag.
    always @(negedge clk) begin
        logic [14:0] tag;
        if (rst_n === 1'b1 && issue === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_issue got rd/rs1/rs2=%h exp=none",
                         {fetch.dec_rd, fetch.dec_rs1, fetch.dec_rs2});
            end else begin
                tag = exp_q.pop_front();
                if ({fetch.dec_rd, fetch.dec_rs1, fetch.dec_rs2} !== tag) begin
                    miscompares++;
                    $display("FAIL sb_issue_tag got=%h exp=%h",
                             {fetch.dec_rd, fetch.dec_rs1, fetch.dec_rs2}, tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        fetch.if_valid            = 1'b0;
        fetch.dec_rd              = 5'd0;
        fetch.dec_rs1             = 5'd0;
        fetch.dec_rs2             = 5'd0;
        fetch.dec_rd_wen          = 1'b0;
        fetch.dec_uses_rs2        = 1'b0;
        fetch.dec_stall           = 1'b0;
        fetch.dec_mem_opcode      = OP_NOP;
        fetch.dec_mem_rdata_valid = 1'b0;
    endtask

    task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic wen, input logic uses2, input logic br,
                           input logic [2:0] op, input logic ld, input logic expect_issue);
        fetch.if_valid            = 1'b1;
        fetch.dec_rd              = rd;
        fetch.dec_rs1             = rs1;
        fetch.dec_rs2             = rs2;
        fetch.dec_rd_wen          = wen;
        fetch.dec_uses_rs2        = uses2;
        fetch.dec_stall           = br;
        fetch.dec_mem_opcode      = op;
        fetch.dec_mem_rdata_valid = ld;
        if (expect_issue) exp_q.push_back({rd, rs1, rs2});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state got=%0d exp=0", state); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL rst_issue got=%b exp=0", issue); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush got=%b exp=0", flush); end
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL rst_bubble got=%b exp=0", bubble); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rst_mem_err got=%b exp=0", mem_err); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
        rst_n = 1'b1;
        exp_stall = 0;
    endtask

    // Load x5, one-cycle memory wait, then ADD reading x5.
    task automatic test_load_use();
        present(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, OP_LD, 1'b1, 1'b1);
        mid();
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL lu_load_issue got=%b exp=1", issue); end
        tick();
        idle();
        mem_ack = 1'b1;
        mid();
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL lu_memwait_state got=%0d exp=2", state); end
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL lu_mem_req got=%b exp=1", mem_req); end
        tick();
        mem_ack = 1'b0;
        present(5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, OP_NOP, 1'b0, 1'b1);
        mid();
        vectors++; if (bubble !== 1'b1) begin miscompares++; $display("FAIL lu_bubble got=%b exp=1", bubble); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL lu_hazard_issue got=%b exp=0", issue); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lu_mem_req_drop got=%b exp=0", mem_req); end
        tick();
        mid();
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL lu_bubble_state got=%0d exp=3", state); end
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_once got=%b exp=0", bubble); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_issue got=%b exp=0", issue); end
        tick();
        mid();
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL lu_add_issue got=%b exp=1", issue); end
        tick();
        idle();
        exp_stall += 2;
        mid();
        vectors++; if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_load_x0();
        present(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, OP_LD, 1'b1, 1'b1);
        tick();
        idle();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        present(5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, OP_NOP, 1'b0, 1'b1);
        mid();
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL x0_bubble got=%b exp=0", bubble); end
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL x0_issue got=%b exp=1", issue); end
        tick();
        idle();
    endtask

    // rs2 collides only when the instruction actually reads rs2.
    task automatic test_rs2_hazard();
        present(5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, OP_LD, 1'b1, 1'b1);
        tick();
        idle();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        present(5'd13, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, OP_NOP, 1'b0, 1'b1);
        mid();
        vectors++; if (bubble !== 1'b1) begin miscompares++; $display("FAIL rs2_bubble got=%b exp=1", bubble); end
        tick();
        tick();
        mid();
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL rs2_issue_after got=%b exp=1", issue); end
        tick();
        exp_stall += 2;
        present(5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, OP_LD, 1'b1, 1'b1);
        tick();
        idle();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        present(5'd14, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, OP_NOP, 1'b0, 1'b1);
        mid();
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL rs2_unused_bubble got=%b exp=0", bubble); end
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL rs2_unused_issue got=%b exp=1", issue); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        // Branch that also flags a memory op: branch wait wins.
        present(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, OP_LD, 1'b0, 1'b1);
        mid();
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL br_issue got=%b exp=1", issue); end
        tick();
        present(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, OP_NOP, 1'b0, 1'b1);
        mem_ack = 1'b1;
        mid();
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL br_wait_state got=%0d exp=1", state); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL br_prec_mem_req got=%b exp=0", mem_req); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL br_wait_issue got=%b exp=0", issue); end
        tick();
        mem_ack = 1'b0;
        tick();
        br_done = 1'b1;
        br_taken = 1'b1;
        mid();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL br_flush got=%b exp=1", flush); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL br_done_issue got=%b exp=0", issue); end
        tick();
        br_done = 1'b0;
        br_taken = 1'b0;
        mid();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_flush_once got=%b exp=0", flush); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL br_back_run got=%0d exp=0", state); end
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL br_next_issue got=%b exp=1", issue); end
        tick();
        idle();
        br_done = 1'b1;
        br_taken = 1'b1;
        mid();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_done_in_run got=%b exp=0", flush); end
        tick();
        br_done = 1'b0;
        br_taken = 1'b0;
        exp_stall += 3;
        mid();
        vectors++; if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL br_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        // Not-taken branch resolves without a flush.
        present(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, 1'b0, 1'b1);
        tick();
        idle();
        br_done = 1'b1;
        mid();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_not_taken_flush got=%b exp=0", flush); end
        tick();
        br_done = 1'b0;
        mid();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL br_not_taken_state got=%0d exp=0", state); end
    endtask

    task automatic test_ack_on_timeout();
        present(5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, OP_ST, 1'b0, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 7; i++) begin
            mid();
            vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ackto_mem_req cyc=%0d got=%b exp=1", i, mem_req); end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mid();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL ackto_state got=%0d exp=0", state); end
        vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL ackto_mem_err got=%b exp=0", mem_err); end
    endtask

    task automatic test_timeout();
        present(5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, OP_ST, 1'b0, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            mid();
            vectors++; if (state !== 2'd2 || mem_err !== 1'b0) begin miscompares++; $display("FAIL to_wait cyc=%0d got state=%0d err=%b exp state=2 err=0", i, state, mem_err); end
            tick();
        end
        mid();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL to_state got=%0d exp=0", state); end
        vectors++; if (mem_err !== 1'b1) begin miscompares++; $display("FAIL to_mem_err got=%b exp=1", mem_err); end
        // A load that times out leaves no pending load-use hazard.
        tick();
        present(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, OP_LD, 1'b1, 1'b1);
        tick();
        idle();
        repeat (8) tick();
        present(5'd12, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, OP_NOP, 1'b0, 1'b1);
        mid();
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("FAIL to_lu_cleared got=%b exp=0", bubble); end
        vectors++; if (mem_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
        tick();
        idle();
    endtask

    task automatic test_reset_abort();
        present(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, OP_ST, 1'b0, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mid();
        vectors++; if (mem_req !== 1'b0 || state !== 2'd0) begin miscompares++; $display("FAIL abort_mem got req=%b state=%0d exp req=0 state=0", mem_req, state); end
        vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL abort_err_clr got=%b exp=0", mem_err); end
        repeat (10) tick();
        vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL abort_no_err got=%b exp=0", mem_err); end
        present(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, 1'b0, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        br_done = 1'b1;
        br_taken = 1'b1;
        mid();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL abort_flush got=%b exp=0", flush); end
        tick();
        br_done = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_stall_saturate();
        present(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, 1'b0, 1'b1);
        tick();
        present(5'd15, 5'd16, 5'd17, 1'b1, 1'b1, 1'b0, OP_NOP, 1'b0, 1'b0);
        repeat (70000) tick();
        mid();
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stall got=%h exp=ffff", stall_cnt); end
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL sat_state got=%0d exp=1", state); end
        tick();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        mid();
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL sat_rst_stall got=%0d exp=0", stall_cnt); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL sat_rst_state got=%0d exp=0", state); end
        vectors++; if ({issue, flush, bubble, mem_req, mem_err} !== 5'b0) begin miscompares++; $display("FAIL sat_rst_outs got=%b exp=00000", {issue, flush, bubble, mem_req, mem_err}); end
    endtask

    initial begin
        rst_n    = 1'b0;
        br_done  = 1'b0;
        br_taken = 1'b0;
        mem_ack  = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_load_x0();
        test_rs2_hazard();
        test_branch();
        test_ack_on_timeout();
        test_timeout();
        test_reset_abort();
        test_stall_saturate();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_pending got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter: MEM_NOP, 3'b111, dec_mem_opcode value meaning no memory access; set to the `MemDoNothing encoding from mem.vh at instantiation.
REQ-002 Parameter: MEM_TIMEOUT, 8, cycles allowed in MEM_WAIT before error (range 1-255).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-005 Port: if_valid  in  1  fetch presents a decoded instruction.
REQ-006 Port: if_ready  out  1  instruction accepted this cycle (combinational).
REQ-007 Port: dec_rd, dec_rs1, dec_rs2  in  5 each  decoded register fields.
REQ-008 Port: dec_rd_wen  in  1  instruction writes rd.
REQ-009 Port: dec_uses_rs2  in  1  instruction reads rs2.
REQ-010 Port: dec_stall  in  1  instruction is a branch.
REQ-011 Port: dec_mem_opcode  in  3  memory operation code.
REQ-012 Port: dec_mem_rdata_valid  in  1  instruction is a load.
REQ-013 Port: br_done, br_taken  in  1 each  branch resolved / taken (br_taken valid only with br_done).
REQ-014 Port: mem_ack  in  1  memory operation complete.
REQ-015 Port: issue  out  1  one-cycle pulse per accepted instruction (equals if_ready).
REQ-016 Port: mem_req  out  1  memory request held high throughout MEM_WAIT.
REQ-017 Port: flush  out  1  one-cycle pulse on taken branch.
REQ-018 Port: bubble  out  1  load-use bubble inserted this cycle.
REQ-019 Port: mem_err  out  1  sticky memory timeout flag.
REQ-020 Port: stall_cnt  out  16  saturating count of cycles with if_valid=1 and if_ready=0.
REQ-021 Port: state  out  2  RUN=0, BR_WAIT=1, MEM_WAIT=2, LU_BUBBLE=3.

Function
REQ-022 if_ready = if_valid & state==RUN & !hazard; hazard defined in REQ-027.
REQ-023 RUN, issue of branch (dec_stall=1): next state BR_WAIT.
REQ-024 RUN, issue with dec_mem_opcode != MEM_NOP: next state MEM_WAIT, mem_req=1 from next cycle, timeout counter cleared to 0.
REQ-025 Branch takes precedence over MEM_WAIT if both flagged.
REQ-026 Load issue (dec_mem_rdata_valid=1, dec_rd_wen=1, dec_rd!=0): capture lu_rd=dec_rd, lu_pend=1; any other issue clears lu_pend.
REQ-027 hazard = lu_pend & ((dec_rs1==lu_rd) | (dec_uses_rs2 & dec_rs2==lu_rd)); evaluated only in RUN with if_valid=1.
REQ-028 RUN with hazard: bubble=1, go to LU_BUBBLE, clear lu_pend; LU_BUBBLE always returns to RUN next cycle with no issue.
REQ-029 BR_WAIT: no issue; on br_done flush=br_taken for that cycle, return to RUN; instruction present that cycle is not accepted.
REQ-030 MEM_WAIT: counter increments each cycle; mem_ack -> mem_req drops next cycle, return to RUN.
REQ-031 MEM_WAIT: counter reaching MEM_TIMEOUT without ack -> mem_err=1 (sticky), lu_pend cleared, return to RUN.
REQ-032 mem_ack in same cycle as timeout: ack wins, mem_err unchanged.
REQ-033 mem_ack outside MEM_WAIT and br_done outside BR_WAIT are ignored.
REQ-034 stall_cnt saturates at 16'hFFFF; never wraps.
REQ-035 rd/rs fields equal to 0 never create a hazard.

Reset
REQ-036 rst_n=0 at a rising edge: state=RUN, lu_pend=0, timeout counter=0, mem_err=0, stall_cnt=0; issue, flush, bubble, mem_req low from that edge.
REQ-037 Reset mid-BR_WAIT or mid-MEM_WAIT abandons the operation; no flush or mem_err generated.

Verification
REQ-038 Load x5 then ADD rs1=x5, back-to-back, mem_ack 1 cycle after request -> load issue, MEM_WAIT 1 cycle, bubble=1 one cycle, ADD issued next cycle; stall_cnt=2.
REQ-039 Load x0 then use x0 -> no bubble, bubble stays 0.
REQ-040 Branch issued, br_done+br_taken 3 cycles later -> flush=1 exactly one cycle, state back to RUN, next instruction issued the following cycle.
REQ-041 Store with mem_ack never returned, MEM_TIMEOUT=8 -> mem_err=1 after 8 MEM_WAIT cycles, state=RUN, mem_err held until reset.
REQ-042 mem_ack on the timeout cycle -> mem_err stays 0.
REQ-043 if_valid held high in BR_WAIT for 70000 cycles -> stall_cnt=16'hFFFF; rst_n low one edge -> all outputs 0, state=RUN.
